// File: rtl/fft_frame_sequencer.sv
// Frame controller for the sequential FFT core. It fills a sample frame, runs the core and streams the result bins out.
// Optional RUN watchdog with a sticky err flag is enabled by defining FFT_SEQ_TIMEOUT_EN.

module fft_seq_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smp_we,
    input  logic [WIDTH-1:0] smp_d,
    input  logic             res_we,
    input  logic [WIDTH-1:0] res_d,
    output logic [WIDTH-1:0] smp_q,
    output logic [WIDTH-1:0] res_q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_q <= '0;
            res_q <= '0;
        end else begin
            if (smp_we) smp_q <= smp_d;
            if (res_we) res_q <= res_d;
        end
    end
endmodule

module fft_frame_sequencer #(
    parameter int SAMPLES = 16,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_last,
    output logic                            fft_rst,
    output logic [SAMPLES-1:0][WIDTH-1:0]   fft_samples,
    input  logic                            fft_out_valid,
    input  logic [SAMPLES-1:0][WIDTH-1:0]   fft_outputs,
    output logic                            busy,
    output logic [15:0]                     lat_cycles,
    output logic                            err
);
    localparam int IW = $clog2(SAMPLES);
    localparam logic [IW-1:0] LAST = IW'(SAMPLES - 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    state_t                          state, state_nx;
    logic [IW-1:0]                   wr_idx, wr_idx_nx, rd_idx, rd_idx_nx;
    logic [15:0]                     run_cnt, run_cnt_nx, lat_nx;
    logic                            smp_we_any, res_we;
    logic [SAMPLES-1:0][WIDTH-1:0]   res_q;

    // One lane per frame word: sample buffer feeding the core plus result latch.
    for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
        fft_seq_lane #(.WIDTH(WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .smp_we (smp_we_any && (wr_idx == IW'(i))),
            .smp_d  (in_data),
            .res_we (res_we),
            .res_d  (fft_outputs[i]),
            .smp_q  (fft_samples[i]),
            .res_q  (res_q[i])
        );
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    logic err_q, err_nx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            wr_idx     <= '0;
            rd_idx     <= '0;
            run_cnt    <= '0;
            lat_cycles <= '0;
        end else begin
            state      <= state_nx;
            wr_idx     <= wr_idx_nx;
            rd_idx     <= rd_idx_nx;
            run_cnt    <= run_cnt_nx;
            lat_cycles <= lat_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        wr_idx_nx  = wr_idx;
        rd_idx_nx  = rd_idx;
        run_cnt_nx = run_cnt;
        lat_nx     = lat_cycles;
        smp_we_any = 1'b0;
        res_we     = 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
        err_nx     = err_q;
`endif
        case (state)
            FILL: begin
                if (in_valid) begin
                    smp_we_any = 1'b1;
                    wr_idx_nx  = wr_idx + 1'b1;
                    if (wr_idx == LAST) begin
                        wr_idx_nx  = '0;
                        run_cnt_nx = '0;
                        state_nx   = RUN;
                    end
                end
            end
            RUN: begin
                run_cnt_nx = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
                // run_cnt == 0 is the core's first cycle out of reset; its valid is stale.
                if (fft_out_valid && (run_cnt != '0)) begin
                    res_we     = 1'b1;
                    lat_nx     = run_cnt;
                    run_cnt_nx = '0;
                    state_nx   = DRAIN;
                end
`ifdef FFT_SEQ_TIMEOUT_EN
                else if (run_cnt == 16'(TIMEOUT - 1)) begin
                    err_nx     = 1'b1;
                    run_cnt_nx = '0;
                    wr_idx_nx  = '0;
                    state_nx   = FILL;
                end
`endif
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_idx_nx = rd_idx + 1'b1;
                    if (rd_idx == LAST) begin
                        rd_idx_nx = '0;
                        state_nx  = FILL;
                    end
                end
            end
            default: state_nx = FILL;
        endcase
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_nx;
    end
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign err            = 1'b0;
`endif

    // All outputs decode registered state only; no input reaches an output combinationally.
    assign in_ready  = (state == FILL);
    assign fft_rst   = (state == RUN);
    assign busy      = (state != FILL);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? res_q[rd_idx] : '0;
    assign out_last  = out_valid && (rd_idx == LAST);

endmodule
